// File: rtl/reg_op_sequencer.sv
// Command sequencer that drives register control strobes for CLR/LOAD/INC/DEC/SHR/SHL.
// Optional macro REG_SEQ_ABORT_EN adds an abort input that cuts an EXEC phase short.
module reg_op_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef REG_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_bit,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic [1:0]            state;
  logic [2:0]            op_q;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  bit_q;
  logic                  abort_now;
  logic                  op_runs;
  logic                  op_repeats;
  logic                  exec_live;

`ifdef REG_SEQ_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  // Decode of the incoming opcode: which ops enter EXEC, and which honour cmd_count.
  always_comb begin
    op_runs    = !(cmd_op == OP_NOP || cmd_op == OP_RSVD);
    op_repeats = (cmd_op == OP_INC) || (cmd_op == OP_DEC) ||
                 (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      remaining <= '0;
      data_q    <= '0;
      bit_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            bit_q     <= cmd_bit;
            remaining <= op_repeats ? cmd_count : '0;
            state     <= op_runs ? ST_EXEC : ST_DONE;
          end
        end
        ST_EXEC: begin
          // remaining holds repeats-minus-one, so all-ones yields 2^CNT_WIDTH cycles without wrapping.
          if (abort_now || remaining == '0) begin
            state <= ST_DONE;
          end else begin
            remaining <= remaining - CNT_WIDTH'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated with rst so they fall with reset, not with the next edge.
  assign exec_live = (state == ST_EXEC) && !rst && !abort_now;

  always_comb begin
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_sl  = 1'b0;
    if (exec_live) begin
      case (op_q)
        OP_CLR:  reg_cl  = 1'b1;
        OP_LOAD: reg_ld  = 1'b1;
        OP_INC:  reg_inc = 1'b1;
        OP_DEC:  reg_dec = 1'b1;
        OP_SHR:  reg_sr  = 1'b1;
        OP_SHL:  reg_sl  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) && !rst;
    busy      = ((state == ST_EXEC) || (state == ST_DONE)) && !rst;
    done      = (state == ST_DONE) && !rst;
    reg_in    = rst ? '0 : data_q;
    reg_ir    = bit_q && !rst;
    reg_il    = bit_q && !rst;
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed self-checking bench for reg_op_sequencer; define REG_SEQ_ABORT_EN to add the abort scenario.
module tb_reg_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_count = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_bit = 1'b0;
  logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
  logic        reg_ir, reg_il;
  logic [15:0] reg_in;
  logic        busy, done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Per-cycle trace; index 0 is the cycle right after the accepting edge.
  logic [5:0]  str_t   [64];
  logic        done_t  [64];
  logic        ready_t [64];
  logic        busy_t  [64];
  logic        il_t    [64];
  logic        ir_t    [64];
  logic [15:0] in_t    [64];

  reg_op_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef REG_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .cmd_data(cmd_data),
    .cmd_bit(cmd_bit),
    .reg_cl(reg_cl),
    .reg_ld(reg_ld),
    .reg_inc(reg_inc),
    .reg_dec(reg_dec),
    .reg_sr(reg_sr),
    .reg_sl(reg_sl),
    .reg_ir(reg_ir),
    .reg_il(reg_il),
    .reg_in(reg_in),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] strobes();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
  endfunction

  // Waits (bounded) for cmd_ready, presents one command, returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [15:0] data, input logic b);
    int unsigned waited = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data; cmd_bit = b;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_data = '0; cmd_bit = 1'b0;
  endtask

  task automatic record(input int unsigned n, input bit toggle);
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      str_t[i] = strobes(); done_t[i] = done; ready_t[i] = cmd_ready; busy_t[i] = busy;
      il_t[i] = reg_il; ir_t[i] = reg_ir; in_t[i] = reg_in;
      if (toggle && i < 15) begin
        cmd_valid = (i % 2 == 0); cmd_op = 3'd2; cmd_data = 16'hFFFF; cmd_bit = 1'b0; cmd_count = 4'd1;
      end else begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_bit = 1'b0; cmd_count = '0;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (strobes() !== 6'b0) begin errors++; $display("FAIL rst_strobes: got %b required 000000", strobes()); end
    checks++; if ({reg_in, reg_ir, reg_il} !== 18'b0) begin errors++; $display("FAIL rst_data: reg_in=%h ir=%b il=%b required 0", reg_in, reg_ir, reg_il); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_load;
    issue(3'd2, 4'd3, 16'hA5C3, 1'b0);
    record(4, 1'b0);
    checks++; if (str_t[0] !== 6'b010000) begin errors++; $display("FAIL load_strobe: got %b required 010000", str_t[0]); end
    checks++; if (in_t[0] !== 16'hA5C3) begin errors++; $display("FAIL load_data: got %h required a5c3", in_t[0]); end
    checks++; if (str_t[1] !== 6'b0 || done_t[1] !== 1'b1 || ready_t[1] !== 1'b0) begin errors++;
      $display("FAIL load_done: strobes=%b done=%b ready=%b required 000000/1/0", str_t[1], done_t[1], ready_t[1]); end
    checks++; if (ready_t[2] !== 1'b1 || done_t[2] !== 1'b0 || busy_t[2] !== 1'b0) begin errors++;
      $display("FAIL load_ready: ready=%b done=%b busy=%b required 1/0/0", ready_t[2], done_t[2], busy_t[2]); end
  endtask

  task automatic test_nop_clr;
    logic [2:0] ops   [3] = '{3'd0, 3'd7, 3'd1};
    logic [5:0] codes [3] = '{6'b000000, 6'b000000, 6'b100000};
    int unsigned lens [3] = '{0, 0, 1};
    for (int unsigned t = 0; t < 3; t++) begin
      issue(ops[t], 4'd9, 16'h0F0F, 1'b1);
      record(lens[t] + 3, 1'b0);
      for (int unsigned i = 0; i < lens[t] + 2; i++) begin
        checks++;
        if (str_t[i] !== ((i < lens[t]) ? codes[t] : 6'b0) || done_t[i] !== (i == lens[t]) ||
            ready_t[i] !== (i == lens[t] + 1)) begin
          errors++;
          $display("FAIL short_op op=%0d cyc=%0d: strobes=%b done=%b ready=%b", ops[t], i, str_t[i], done_t[i], ready_t[i]);
        end
      end
    end
  endtask

  task automatic test_repeat;
    logic [2:0] ops   [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
    logic [3:0] cnts  [4] = '{4'd4, 4'd1, 4'd2, 4'd0};
    logic [5:0] codes [4] = '{6'b001000, 6'b000100, 6'b000010, 6'b000001};
    logic       bits  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int unsigned t = 0; t < 4; t++) begin
      int unsigned n = 32'(cnts[t]) + 1;
      int unsigned dones = 0;
      issue(ops[t], cnts[t], 16'h3C00 + 16'(t), bits[t]);
      record(n + 3, 1'b0);
      for (int unsigned i = 0; i < n + 2; i++) begin
        dones += 32'(done_t[i]);
        checks++;
        if (str_t[i] !== ((i < n) ? codes[t] : 6'b0) || done_t[i] !== (i == n) || ready_t[i] !== (i == n + 1)) begin
          errors++;
          $display("FAIL repeat op=%0d cyc=%0d: strobes=%b done=%b ready=%b", ops[t], i, str_t[i], done_t[i], ready_t[i]);
        end
      end
      checks++;
      if (dones != 1 || ir_t[0] !== bits[t] || il_t[0] !== bits[t]) begin
        errors++;
        $display("FAIL repeat_misc op=%0d: done_pulses=%0d ir=%b il=%b required 1/%b/%b", ops[t], dones, ir_t[0], il_t[0], bits[t], bits[t]);
      end
    end
  endtask

  task automatic test_shl_full;
    int unsigned sl_cycles = 0;
    issue(3'd6, 4'hF, 16'h1234, 1'b1);
    record(19, 1'b1);
    for (int unsigned i = 0; i < 16; i++) begin
      sl_cycles += (str_t[i] === 6'b000001) ? 1 : 0;
      checks++;
      if (il_t[i] !== 1'b1 || in_t[i] !== 16'h1234) begin
        errors++;
        $display("FAIL shl_latched cyc=%0d: il=%b reg_in=%h required 1/1234", i, il_t[i], in_t[i]);
      end
    end
    checks++; if (sl_cycles != 16) begin errors++; $display("FAIL shl_len: got %0d cycles required 16", sl_cycles); end
    checks++; if (str_t[16] !== 6'b0 || done_t[16] !== 1'b1) begin errors++;
      $display("FAIL shl_done: strobes=%b done=%b required 000000/1", str_t[16], done_t[16]); end
    checks++; if (ready_t[17] !== 1'b1 || done_t[17] !== 1'b0 || busy_t[18] !== 1'b0) begin errors++;
      $display("FAIL shl_ready: ready=%b done=%b busy=%b required 1/0/0", ready_t[17], done_t[17], busy_t[18]); end
  endtask

  task automatic test_reset_mid_dec;
    issue(3'd4, 4'd7, 16'hBEEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (strobes() !== 6'b000100) begin errors++; $display("FAIL dec_third: got %b required 000100", strobes()); end
    rst = 1'b1;
    #1;
    checks++; if (strobes() !== 6'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL dec_rst_async: strobes=%b busy=%b done=%b required 0", strobes(), busy, done); end
    checks++; if (reg_in !== 16'h0 || reg_il !== 1'b0 || cmd_ready !== 1'b0) begin errors++;
      $display("FAIL dec_rst_outs: reg_in=%h il=%b ready=%b required 0", reg_in, reg_il, cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL dec_release_ready: got %b required 1", cmd_ready); end
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || strobes() !== 6'b0 || cmd_ready !== 1'b1) begin errors++;
        $display("FAIL dec_after cyc=%0d: done=%b strobes=%b ready=%b required 0/0/1", i, done, strobes(), cmd_ready); end
    end
  endtask

  task automatic test_back_to_back;
    issue(3'd3, 4'd0, 16'h0001, 1'b0);
    record(2, 1'b0);
    checks++; if (str_t[0] !== 6'b001000 || done_t[1] !== 1'b1) begin errors++;
      $display("FAIL b2b_first: strobes=%b done=%b required 001000/1", str_t[0], done_t[1]); end
    issue(3'd2, 4'd0, 16'h8001, 1'b0);
    record(1, 1'b0);
    checks++; if (str_t[0] !== 6'b010000 || in_t[0] !== 16'h8001) begin errors++;
      $display("FAIL b2b_second: strobes=%b reg_in=%h required 010000/8001", str_t[0], in_t[0]); end
  endtask

`ifdef REG_SEQ_ABORT_EN
  task automatic test_abort;
    issue(3'd5, 4'd5, 16'h00AA, 1'b1);
    checks++; if (strobes() !== 6'b000010) begin errors++; $display("FAIL abort_first: got %b required 000010", strobes()); end
    @(negedge clk);
    abort = 1'b1;
    #1;
    checks++; if (strobes() !== 6'b0) begin errors++; $display("FAIL abort_same_cycle: got %b required 000000", strobes()); end
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || strobes() !== 6'b0) begin errors++;
      $display("FAIL abort_done: done=%b strobes=%b required 1/000000", done, strobes()); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL abort_ready: ready=%b done=%b required 1/0", cmd_ready, done); end
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_nop_clr;
    test_repeat;
    test_shl_full;
    test_reset_mid_dec;
    test_back_to_back;
`ifdef REG_SEQ_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the register data path driven by this block.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, width of the repeat-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_op  input  3  opcode: 0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 reserved.
REQ-008 SHALL have port cmd_count  input  CNT_WIDTH  repetitions minus one, for INC/DEC/SHR/SHL.
REQ-009 SHALL have port cmd_data  input  DATA_WIDTH  load value for LOAD.
REQ-010 SHALL have port cmd_bit  input  1  bit shifted in for SHR/SHL.
REQ-011 SHALL have ports reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  output  1 each  register control strobes.
REQ-012 SHALL have ports reg_ir, reg_il  output  1 each  shift-in bits; reg_in  output  DATA_WIDTH  load data.
REQ-013 SHALL have port busy  output  1  high while in EXEC or DONE.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE; cmd_ready = 1 only in IDLE with rst low.
REQ-016 SHALL accept a command on a rising edge with cmd_valid & cmd_ready, latching op, count, data and bit.
REQ-017 SHALL, on acceptance of CLR, LOAD, INC, DEC, SHR or SHL, go to EXEC; on NOP or op 7, go directly to DONE with no strobe.
REQ-018 SHALL execute CLR and LOAD for exactly 1 EXEC cycle, ignoring cmd_count.
REQ-019 SHALL execute INC, DEC, SHR and SHL for exactly cmd_count+1 consecutive EXEC cycles, using an internal remaining counter of CNT_WIDTH bits.
REQ-020 SHALL assert exactly one strobe, the one matching the latched op, during every EXEC cycle, with all strobes 0 outside EXEC.
REQ-021 SHALL drive reg_in with the latched data, and reg_ir and reg_il with the latched bit, whenever not in reset; these outputs are 0 in reset.
REQ-022 SHALL, on the final EXEC cycle (remaining = 0), go to DONE; DONE lasts 1 cycle with done = 1, then the FSM returns to IDLE.
REQ-023 SHALL have the following latency: command accepted at edge k; strobes high during cycles k+1 .. k+N; done high during cycle k+N+1; cmd_ready high again from cycle k+N+2.
REQ-024 SHALL ignore cmd_valid and all cmd_* inputs outside IDLE; the latched values SHALL NOT change mid-operation.
REQ-025 SHALL produce 2^CNT_WIDTH repetitions for cmd_count = all ones, with no wrap of the remaining counter.

Reset
REQ-026 SHALL, while rst is high, hold state in IDLE and keep all outputs at 0, including cmd_ready, busy, done, the strobes, reg_in, reg_ir and reg_il.
REQ-027 SHALL, when rst asserts mid-EXEC, drop all strobes immediately and asynchronously, with no done pulse; the aborted command is lost.
REQ-028 SHALL have cmd_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with macro REG_SEQ_ABORT_EN defined, add port abort  input  1; abort high in EXEC SHALL deassert strobes in that same cycle and move the FSM to DONE on the next edge, and done still pulses.
REQ-030 SHALL, without REG_SEQ_ABORT_EN, have no abort port, and every command SHALL run to completion.

Verification
REQ-031 SHALL cover: LOAD with cmd_data=16'hA5C3 accepted at edge k -> reg_ld=1 and reg_in=16'hA5C3 for 1 cycle; done during cycle k+2; cmd_ready high during cycle k+3.
REQ-032 SHALL cover: INC with cmd_count=4 -> reg_inc high exactly 5 consecutive cycles; no other strobe; one done pulse.
REQ-033 SHALL cover: SHL with cmd_count=4'hF and cmd_bit=1 -> reg_sl high 16 cycles; reg_il=1 throughout; cmd_valid toggled during EXEC has no effect.
REQ-034 SHALL cover: NOP and op 7 -> no strobe; done during cycle k+1; cmd_ready back during cycle k+2.
REQ-035 SHALL cover: rst pulsed during the 3rd cycle of an 8-cycle DEC -> strobes drop the same cycle; no done; cmd_ready=1 in the first cycle after release.
REQ-036 SHALL cover, with REG_SEQ_ABORT_EN: abort in the 2nd cycle of SHR with cmd_count=5 -> reg_sr high 1 cycle only, then done pulse.
